// File: rtl/bl_wl_config_writer.sv
// bl_wl_config_writer
//   Programs a bit-line/word-line configuration memory bank one row at a time.
//   Config words arrive over a valid/ready stream and are packed into a row
//   shadow register. When a row is complete it is presented on bl, and then
//   the row's word-line is strobed for WL_PULSE cycles. This repeats for all
//   NUM_WL rows, and the block finishes with a single-cycle done pulse.
//
// Ports
//   prog_clk    in   programming clock (rising edge)
//   prog_rst_n  in   synchronous active-low reset
//   start       in   request to program the whole bank (honoured in IDLE only)
//   abort       in   abandon programming, return to IDLE
//   cfg_data    in   DATA_W config word; cfg_data[0] maps to the lowest column
//   cfg_valid   in   cfg_data valid
//   cfg_ready   out  word accepted this cycle (high only in LOAD)
//   bl          out  [0:NUM_BL-1] bit-line data, bl[c] is column c
//   wl          out  [0:NUM_WL-1] word-line strobe, zero or one-hot
//   busy        out  high during LOAD/SETUP/PULSE/HOLD
//   done        out  one-cycle pulse after the last row is written
module bl_wl_config_writer #(
  parameter int NUM_BL   = 158,
  parameter int NUM_WL   = 158,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [0:NUM_BL-1]   bl,
  output logic [0:NUM_WL-1]   wl,
  output logic                busy,
  output logic                done
);

  localparam int WPR    = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int ROW_W  = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int PCNT_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [ROW_W-1:0]    row_q;
  logic [WORD_W-1:0]   word_q;
  logic [PCNT_W-1:0]   pcnt_q;
  logic [0:NUM_BL-1]   shadow_q;
  logic [0:NUM_BL-1]   shadow_d;
  logic [0:NUM_BL-1]   bl_q;
  logic [0:NUM_WL-1]   wl_q;
  logic                busy_q;
  logic                done_q;
  logic                last_word;
  logic                last_row;
  logic                last_pulse;

  assign cfg_ready  = (state_q == S_LOAD);
  assign bl         = bl_q;
  assign wl         = wl_q;
  assign busy       = busy_q;
  assign done       = done_q;

  assign last_word  = (word_q == WORD_W'(WPR - 1));
  assign last_row   = (row_q == ROW_W'(NUM_WL - 1));
  assign last_pulse = (pcnt_q == PCNT_W'(WL_PULSE - 1));

  // Shadow with the current input word merged into its column slot. Columns
  // past NUM_BL-1 simply do not exist, so the top bits of a partial last word
  // fall away naturally.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned c = 0; c < NUM_BL; c++) begin
      if ((c / DATA_W) == 32'(word_q)) begin
        shadow_d[c] = cfg_data[c % DATA_W];
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      word_q   <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      bl_q     <= '0;
      wl_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      // bl deliberately keeps its value; only the partial row is thrown away.
      state_q  <= S_IDLE;
      word_q   <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      wl_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            row_q   <= '0;
            word_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            shadow_q <= shadow_d;
            if (last_word) begin
              bl_q    <= shadow_d;
              state_q <= S_SETUP;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        S_SETUP: begin
          pcnt_q       <= '0;
          wl_q         <= '0;
          wl_q[row_q]  <= 1'b1;
          state_q      <= S_PULSE;
        end
        S_PULSE: begin
          if (last_pulse) begin
            wl_q    <= '0;
            state_q <= S_HOLD;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (last_row) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q   <= row_q + 1'b1;
            word_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          wl_q    <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bl_wl_config_writer.sv
// Directed bench for bl_wl_config_writer with a 10-column, 3-row bank.
// Expected bl values are written column-indexed (bit c = column c).
module tb_bl_wl_config_writer;

  logic          prog_clk;
  logic          prog_rst_n;
  logic          start;
  logic          abort;
  logic [7:0]    cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [0:9]    bl;
  logic [0:2]    wl;
  logic          busy;
  logic          done;

  int n_vec;
  int n_bad;
  int done_cnt;

  bl_wl_config_writer #(
    .NUM_BL   (10),
    .NUM_WL   (3),
    .DATA_W   (8),
    .WL_PULSE (2)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .bl         (bl),
    .wl         (wl),
    .busy       (busy),
    .done       (done)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  always @(negedge prog_clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] blcol();
    logic [9:0] r;
    for (int c = 0; c < 10; c++) r[c] = bl[c];
    return r;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_bl"},    32'(blcol()), 32'h0);
    check({tag, "_wl"},    32'(wl), 32'h0);
    check({tag, "_ready"}, 32'(cfg_ready), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
  endtask

  // Entered just after an edge with the DUT in LOAD. Feeds one row, optionally
  // stalling `gap` cycles between the two words, and checks every cycle until
  // the next LOAD or the DONE/IDLE cycles.
  task automatic do_row(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [9:0] exp_bl, input logic [9:0] prev_bl,
                        input logic [2:0] exp_wl, input int gap, input bit last);
    check("load_ready", 32'(cfg_ready), 32'h1);
    check("load_wl", 32'(wl), 32'h0);
    cfg_valid = 1'b1; cfg_data = w0;
    tick();
    for (int g = 0; g < gap; g++) begin
      cfg_valid = 1'b0; cfg_data = 8'h00;
      check("gap_ready", 32'(cfg_ready), 32'h1);
      check("gap_wl", 32'(wl), 32'h0);
      check("gap_bl", 32'(blcol()), 32'(prev_bl));
      tick();
    end
    check("w1_ready", 32'(cfg_ready), 32'h1);
    check("w1_bl", 32'(blcol()), 32'(prev_bl));
    cfg_valid = 1'b1; cfg_data = w1;
    tick();
    cfg_valid = 1'b0; cfg_data = 8'h00;
    check("setup_bl", 32'(blcol()), 32'(exp_bl));
    check("setup_wl", 32'(wl), 32'h0);
    check("setup_ready", 32'(cfg_ready), 32'h0);
    check("setup_busy", 32'(busy), 32'h1);
    tick();
    check("pulse1_wl", 32'(wl), 32'(exp_wl));
    check("pulse1_bl", 32'(blcol()), 32'(exp_bl));
    tick();
    check("pulse2_wl", 32'(wl), 32'(exp_wl));
    check("pulse2_bl", 32'(blcol()), 32'(exp_bl));
    tick();
    check("hold_wl", 32'(wl), 32'h0);
    check("hold_busy", 32'(busy), 32'h1);
    check("hold_ready", 32'(cfg_ready), 32'h0);
    tick();
    if (last) begin
      check("done_pulse", 32'(done), 32'h1);
      check("done_busy", 32'(busy), 32'h0);
      check("done_ready", 32'(cfg_ready), 32'h0);
      tick();
      check("idle_done", 32'(done), 32'h0);
      check("idle_ready", 32'(cfg_ready), 32'h0);
      check("idle_bl", 32'(blcol()), 32'(exp_bl));
    end else begin
      check("next_ready", 32'(cfg_ready), 32'h1);
      check("next_done", 32'(done), 32'h0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'h1);
  endtask

  int base;

  initial begin
    n_vec = 0; n_bad = 0; done_cnt = 0;
    prog_rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'hFF;

    // Reset dominates start/valid
    tick(); tick(); tick();
    check_idle_zero("rst");
    prog_rst_n = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    tick();
    check_idle_zero("post_rst");

    // Full program, back-to-back
    base = done_cnt;
    do_start();
    do_row(8'hA5, 8'h02, 10'h2A5, 10'h000, 3'b100, 0, 1'b0);
    do_row(8'h5A, 8'h01, 10'h15A, 10'h2A5, 3'b010, 0, 1'b0);
    do_row(8'hFF, 8'h03, 10'h3FF, 10'h15A, 3'b001, 0, 1'b1);
    tick(); tick();
    check("full_bl_held", 32'(blcol()), 32'h3FF);
    check("full_done_cnt", 32'(done_cnt - base), 32'h1);

    // Truncation on row 0, backpressure gap on row 1
    base = done_cnt;
    do_start();
    do_row(8'h00, 8'hFF, 10'h300, 10'h3FF, 3'b100, 0, 1'b0);
    do_row(8'h0F, 8'h00, 10'h00F, 10'h300, 3'b010, 5, 1'b0);
    do_row(8'hC3, 8'h02, 10'h2C3, 10'h00F, 3'b001, 0, 1'b1);
    check("trunc_done_cnt", 32'(done_cnt - base), 32'h1);

    // Abort during row 1 pulse, then restart from row 0
    base = done_cnt;
    do_start();
    do_row(8'h11, 8'h00, 10'h011, 10'h2C3, 3'b100, 0, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'h22; tick();
    cfg_data = 8'h01; tick();
    cfg_valid = 1'b0; tick();
    check("abort_pre_wl", 32'(wl), 32'h2);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_wl", 32'(wl), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ready", 32'(cfg_ready), 32'h0);
    check("abort_bl", 32'(blcol()), 32'h122);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_idle_ready", 32'(cfg_ready), 32'h0);
    tick(); tick();
    check("abort_no_done", 32'(done_cnt - base), 32'h0);
    do_start();
    do_row(8'h33, 8'h02, 10'h233, 10'h122, 3'b100, 0, 1'b0);
    do_row(8'h44, 8'h01, 10'h144, 10'h233, 3'b010, 0, 1'b0);
    do_row(8'h55, 8'h00, 10'h055, 10'h144, 3'b001, 0, 1'b1);
    check("restart_done_cnt", 32'(done_cnt - base), 32'h1);

    // start during row 1 LOAD is ignored
    base = done_cnt;
    do_start();
    do_row(8'h01, 8'h01, 10'h101, 10'h055, 3'b100, 0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    do_row(8'h80, 8'h02, 10'h280, 10'h101, 3'b010, 0, 1'b0);
    do_row(8'h7E, 8'h01, 10'h17E, 10'h280, 3'b001, 0, 1'b1);
    check("restart_ign_done_cnt", 32'(done_cnt - base), 32'h1);

    // Reset mid-LOAD
    do_start();
    do_row(8'hAA, 8'h03, 10'h3AA, 10'h17E, 3'b100, 0, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'h99; tick();
    prog_rst_n = 1'b0; tick();
    cfg_valid = 1'b0;
    check_idle_zero("midrst");
    prog_rst_n = 1'b1; tick();
    check("midrst_idle_ready", 32'(cfg_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
